// File: rtl/piso_tx.sv
// UART transmit serializer: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits, every bit held for OVERSAMPLE baud-clock cycles.
module piso_tx #(
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       i_baudclk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_txd,
  output logic       o_busy,
  output logic       o_done,
  output logic [2:0] o_dbg_state
);

  // Handshake: a byte is taken on the rising edge where i_valid && o_ready;
  // o_ready is high only in IDLE, and i_valid is ignored everywhere else.

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic             stop_q, stop_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             txd_q, txd_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  // txd_d is the line value for the cycle after the edge, so it follows state_d.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        txd_d = 1'b1;
        if (i_valid) begin
          shift_d = i_data;
          par_d   = (^i_data) ^ ODD;
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              txd_d   = par_q;
            end else begin
              state_d = STOP;
              stop_d  = 1'b0;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          cnt_d   = '0;
          stop_d  = 1'b0;
          txd_d   = 1'b1;
        end
      end
      STOP: begin
        txd_d = 1'b1;
        if (bit_end) begin
          cnt_d = '0;
          if (stop_q == STOP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        txd_d   = 1'b1;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_baudclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      stop_q  <= 1'b0;
      shift_q <= 8'd0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_txd       = txd_q;
  assign o_ready     = ready_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_dbg_state = state_q;

endmodule
